// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder controller that streams one nibble per cycle through an
// external 4-bit carry-lookahead adder, chaining the carry between slices.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_c_in,
  input  logic [3:0]       cla_sum,
  input  logic             cla_c_out
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] idx;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic            carry_reg;
  logic            last_slice;

  assign last_slice = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    cla_a     = '0;
    cla_b     = '0;
    cla_c_in  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy     = 1'b1;
        cla_a    = a_reg[{idx, 2'b00} +: 4];
        cla_b    = b_reg[{idx, 2'b00} +: 4];
        cla_c_in = carry_reg;
        if (last_slice) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg     <= op_a;
          b_reg     <= op_b;
          carry_reg <= c_in;
          idx       <= '0;
          result    <= '0;
          c_out     <= 1'b0;
          overflow  <= 1'b0;
        end
        RUN: begin
          result[{idx, 2'b00} +: 4] <= cla_sum;
          carry_reg <= cla_c_out;
          if (last_slice) begin
            idx      <= '0;
            c_out    <= cla_c_out;
            // Sign bit of the sum is the top bit of the final slice
            overflow <= (a_reg[WIDTH-1] & b_reg[WIDTH-1] & ~cla_sum[3]) |
                        (~a_reg[WIDTH-1] & ~b_reg[WIDTH-1] & cla_sum[3]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with a behavioural 4-bit adder
// closing the loop on the cla_* ports.
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a, op_b;
  logic        c_in;
  logic        busy, done;
  logic [15:0] result;
  logic        c_out, overflow;
  logic [3:0]  cla_a, cla_b, cla_sum;
  logic        cla_c_in, cla_c_out;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #10 clk = ~clk;

  assign {cla_c_out, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_c_in};

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .c_in(c_in),
    .busy(busy), .done(done), .result(result), .c_out(c_out), .overflow(overflow),
    .cla_a(cla_a), .cla_b(cla_b), .cla_c_in(cla_c_in),
    .cla_sum(cla_sum), .cla_c_out(cla_c_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one add, wait for done, and check its timing and result.
  task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic [15:0] exp_res,
                         input logic exp_co, input logic exp_ov);
    int unsigned cycles;
    int unsigned busy_cnt;
    op_a = a; op_b = b; c_in = ci; start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    busy_cnt = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      tick();
      cycles++;
    end
    if (busy) busy_cnt++;
    check({tag, "_done_lat"}, cycles, 4);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_c_out"}, c_out, exp_co);
    check({tag, "_ovf"}, overflow, exp_ov);
    tick();
    check({tag, "_busy_cnt"}, busy_cnt, 5);
    check({tag, "_idle"}, {busy, done}, 2'b00);
    check({tag, "_hold"}, result, exp_res);
  endtask

  logic [15:0] bb_a   [3] = '{16'h0001, 16'hFFFF, 16'h4000};
  logic [15:0] bb_b   [3] = '{16'h0002, 16'hFFFF, 16'h4000};
  logic [15:0] bb_res [3] = '{16'h0003, 16'hFFFE, 16'h8000};
  logic        bb_co  [3] = '{1'b0, 1'b1, 1'b0};
  logic        bb_ov  [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; c_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_outs", {busy, done, c_out, overflow}, 4'b0000);
    check("rst_result", result, 16'h0000);
    check("rst_cla", {cla_a, cla_b, cla_c_in}, 9'h000);

    run_add("a1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Carry ripple across slices: cla_c_in 0,1,1,1 and first slice operands
    op_a = 16'hFFFF; op_b = 16'h0001; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("cin_s0", cla_c_in, 1'b0);
    check("cla_a_s0", cla_a, 4'hF);
    check("cla_b_s0", cla_b, 4'h1);
    tick(); check("cin_s1", cla_c_in, 1'b1);
    tick(); check("cin_s2", cla_c_in, 1'b1);
    tick(); check("cin_s3", cla_c_in, 1'b1);
    tick();
    check("ffff_done", done, 1'b1);
    check("ffff_result", result, 16'h0000);
    check("ffff_co_ov", {c_out, overflow}, 2'b10);
    check("done_cla_zero", {cla_a, cla_b, cla_c_in}, 9'h000);
    tick();

    run_add("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_add("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_add("cin", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

    // Start during RUN must be ignored
    op_a = 16'h0000; op_b = 16'h0000; c_in = 1'b1; start = 1'b1;
    tick();
    op_a = 16'hAAAA;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("ign_done", done, 1'b1);
    check("ign_result", result, 16'h0001);
    tick(); tick();
    check("ign_no_restart", busy, 1'b0);

    // Asynchronous reset mid-RUN
    op_a = 16'h1111; op_b = 16'h2222; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("mid_partial", result, 16'h0033);
    rst = 1'b1;
    #1;
    check("arst_outs", {busy, done, c_out, overflow}, 4'b0000);
    check("arst_result", result, 16'h0000);
    check("arst_cla", {cla_a, cla_b, cla_c_in}, 9'h000);
    tick();
    rst = 1'b0;
    begin
      int unsigned seen = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (done || busy) seen++;
      end
      check("arst_no_done", seen, 0);
    end
    run_add("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Back-to-back with start held high: one accept every 6 cycles
    op_a = bb_a[0]; op_b = bb_b[0]; c_in = 1'b0; start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin op_a = bb_a[k+1]; op_b = bb_b[k+1]; end
      else start = 1'b0;
      tick(); tick(); tick();
      check($sformatf("b2b%0d_not_done", k), done, 1'b0);
      tick();
      check($sformatf("b2b%0d_done", k), done, 1'b1);
      check($sformatf("b2b%0d_result", k), result, bb_res[k]);
      check($sformatf("b2b%0d_co_ov", k), {c_out, overflow}, {bb_co[k], bb_ov[k]});
      tick();
      check($sformatf("b2b%0d_gap", k), busy, 1'b0);
      tick();
      check($sformatf("b2b%0d_next", k), busy, (k < 2) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
